uart_scheduler: RTL

UART_SCHEDULER -- requirements
Module: uart_scheduler

---
 rtl/uart_sched_pkg.sv | 11 +
 rtl/uart_sched_rr2.sv | 15 +
 rtl/uart_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared enums, register offsets and status-bit positions for the UART scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;
  typedef enum logic [2:0] {OP_DIV_WR, OP_RX_RD, OP_RX_CLR, OP_TX_ST, OP_TX_WR} op_e;
  localparam logic [3:0] RX_OFS  = 4'h0;
  localparam logic [3:0] TX_OFS  = 4'h4;
  localparam logic [3:0] DIV_OFS = 4'h8;
  localparam int RX_EMPTY_BIT = 31;
  localparam int RX_ERR_BIT   = 8;
  localparam int TX_FULL_BIT  = 31;
endpackage

// File: rtl/uart_sched_rr2.sv
// uart_sched_rr2: two-requester round-robin grant with registered last-grant
module uart_sched_rr2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_idx_i,
  output logic       gnt_o
);
  logic last_q;
  assign gnt_o = (&req_i) ? ~last_q : req_i[1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_q <= 1'b1;
    else if (upd_i) last_q <= upd_idx_i;
endmodule

// File: rtl/uart_scheduler.sv
// uart_scheduler: APB master sequencing UART divisor, TX and RX register traffic.
// RX polling, rx_err and error clearing exist only when UART_SCHED_RX_EN is defined.
import uart_sched_pkg::*;
module uart_scheduler #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter logic [3:0]  ADDR_RX       = RX_OFS,
  parameter logic [3:0]  ADDR_TX       = TX_OFS,
  parameter logic [3:0]  ADDR_DIV      = DIV_OFS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx0_valid,
  output logic        tx0_ready,
  input  logic [7:0]  tx0_data,
  input  logic        tx1_valid,
  output logic        tx1_ready,
  input  logic [7:0]  tx1_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_err,
  input  logic        div_load,
  input  logic [15:0] div_value,
  output logic        busy,
  output logic [3:0]  apb_PADDR,
  output logic        apb_PSEL,
  output logic        apb_PENABLE,
  output logic        apb_PWRITE,
  output logic [31:0] apb_PWDATA,
  input  logic        apb_PREADY,
  input  logic [31:0] apb_PRDATA
);
  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [3:0]  paddr_q, paddr_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        gnt_q, gnt_d;
  logic [7:0]  byte_q, byte_d;
  logic [15:0] div_q, div_d;
  logic        div_pend_q, div_pend_d, clr_pend_q, clr_pend_d;
  logic        rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rr_gnt, done, rx_due, unused_ok;
  assign done        = state_q == S_ACCESS && apb_PREADY;
  assign apb_PSEL    = state_q != S_IDLE;
  assign apb_PENABLE = state_q == S_ACCESS;
  assign busy        = apb_PSEL;
  assign apb_PADDR   = paddr_q;
  assign apb_PWRITE  = pwrite_q;
  assign apb_PWDATA  = pwdata_q;
  assign tx0_ready   = done && op_q == OP_TX_WR && !gnt_q;
  assign tx1_ready   = done && op_q == OP_TX_WR && gnt_q;
  assign unused_ok   = ^apb_PRDATA[30:9];
  uart_sched_rr2 u_rr (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     ({tx1_valid, tx0_valid}),
    .upd_i     (done && op_q == OP_TX_WR),
    .upd_idx_i (gnt_q),
    .gnt_o     (rr_gnt)
  );
`ifdef UART_SCHED_RX_EN
  logic [15:0] timer_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timer_q <= 16'(POLL_INTERVAL);
    else if (done && op_q == OP_RX_RD) timer_q <= 16'(POLL_INTERVAL);
    else if (timer_q != 16'd0) timer_q <= timer_q - 16'd1;
  assign rx_due   = timer_q == 16'd0 && !rx_valid_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_err   = rx_err_q;
`else
  logic unused_rx;
  assign unused_rx = ^{rx_valid_q, rx_data_q, rx_err_q};
  assign rx_due    = 1'b0;
  assign rx_valid  = 1'b0;
  assign rx_data   = 8'h00;
  assign rx_err    = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    gnt_d      = gnt_q;
    byte_d     = byte_q;
    div_d      = div_q;
    div_pend_d = div_pend_q;
    clr_pend_d = clr_pend_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    rx_data_d  = rx_data_q;
    rx_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_pend_q || div_pend_q || rx_due || tx0_valid || tx1_valid) state_d = S_SETUP;
        if (clr_pend_q) begin
          op_d = OP_RX_CLR; paddr_d = ADDR_RX; pwrite_d = 1'b1; pwdata_d = '0; clr_pend_d = 1'b0;
        end else if (div_pend_q) begin
          op_d = OP_DIV_WR; paddr_d = ADDR_DIV; pwrite_d = 1'b1; pwdata_d = {16'b0, div_q}; div_pend_d = 1'b0;
        end else if (rx_due) begin
          op_d = OP_RX_RD; paddr_d = ADDR_RX; pwrite_d = 1'b0; pwdata_d = '0;
        end else if (tx0_valid || tx1_valid) begin
          op_d = OP_TX_ST; paddr_d = ADDR_TX; pwrite_d = 1'b0; pwdata_d = '0;
          gnt_d = rr_gnt; byte_d = rr_gnt ? tx1_data : tx0_data;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: if (apb_PREADY) begin
        state_d = S_IDLE;
        // an error report wins over any byte carried in the same status word
        if (op_q == OP_RX_RD && apb_PRDATA[RX_ERR_BIT]) begin
          rx_err_d = 1'b1; clr_pend_d = 1'b1;
        end else if (op_q == OP_RX_RD && !apb_PRDATA[RX_EMPTY_BIT]) begin
          rx_valid_d = 1'b1; rx_data_d = apb_PRDATA[7:0];
        end
        if (op_q == OP_TX_ST && !apb_PRDATA[TX_FULL_BIT]) begin
          state_d = S_SETUP; op_d = OP_TX_WR; pwrite_d = 1'b1; pwdata_d = {24'b0, byte_q};
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (div_load) begin
      div_d = div_value; div_pend_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_DIV_WR;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      gnt_q      <= 1'b0;
      byte_q     <= '0;
      div_q      <= '0;
      div_pend_q <= 1'b0;
      clr_pend_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      gnt_q      <= gnt_d;
      byte_q     <= byte_d;
      div_q      <= div_d;
      div_pend_q <= div_pend_d;
      clr_pend_q <= clr_pend_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_err_q   <= rx_err_d;
    end
endmodule
